// File: rtl/output_layer_sequencer_if.sv
// output_layer_sequencer_if: handshake bundle between the output-layer sequencer and its environment
// Signals:
//   start / busy                          classification request and activity flag
//   neuron_req / neuron_idx               request to the shared neuron unit
//   neuron_done / neuron_score            score returned by the shared neuron unit
//   result_valid / result_ready           result handshake
//   Img_Num / max_score / err             winning class, winning score, timeout flag
// Modports: master = sequencer side, slave = environment side.
interface output_layer_sequencer_if #(
    parameter int SCORE_W = 26,
    parameter int IDX_W   = 4
);
    logic                      start;
    logic                      busy;
    logic                      neuron_req;
    logic [IDX_W-1:0]          neuron_idx;
    logic                      neuron_done;
    logic signed [SCORE_W-1:0] neuron_score;
    logic                      result_valid;
    logic                      result_ready;
    logic [IDX_W-1:0]          Img_Num;
    logic signed [SCORE_W-1:0] max_score;
    logic                      err;

    modport master (
        input  start, neuron_done, neuron_score, result_ready,
        output busy, neuron_req, neuron_idx, result_valid, Img_Num, max_score, err
    );

    modport slave (
        output start, neuron_done, neuron_score, result_ready,
        input  busy, neuron_req, neuron_idx, result_valid, Img_Num, max_score, err
    );
endinterface

// File: rtl/output_layer_sequencer.sv
// output_layer_sequencer: runs the output neurons one at a time through a shared unit and reports the argmax
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        output_layer_sequencer_if.master (start/busy, neuron req/idx/done/score,
//              result valid/ready, Img_Num, max_score, err)
// Optional feature: define SEQ_TIMEOUT_EN to abandon a neuron after TIMEOUT_CYC WAIT cycles
// and finish with err=1; otherwise err is tied low and WAIT holds indefinitely.
module output_layer_sequencer #(
    parameter int SCORE_W     = 26,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic clk,
    input logic rst,
    output_layer_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                    state, state_n;
    logic [IDX_W-1:0]          cnt;
    logic [IDX_W-1:0]          img_num;
    logic signed [SCORE_W-1:0] best;
    logic                      last;
    logic                      take;
    logic                      tmo;
    logic                      err_q;

    if ((2 ** IDX_W) <= NUM_CLASSES || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("output_layer_sequencer: invalid parameters");
    end

    assign last = cnt == IDX_W'(NUM_CLASSES - 1);
    // The first score always wins; afterwards strict > keeps the lower index on ties.
    assign take = cnt == '0 || $signed(bus.neuron_score) > $signed(best);

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wcnt;
    // Every WAIT is entered from ISSUE, so zeroing outside WAIT restarts the count per neuron.
    assign tmo = state == WAIT && !bus.neuron_done && wcnt == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) wcnt <= '0;
        else wcnt <= wcnt + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst || (state == DONE && bus.result_ready)) err_q <= 1'b0;
        else if (tmo) err_q <= 1'b1;
    end
`else
    assign tmo   = 1'b0;
    assign err_q = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = bus.neuron_done ? (last ? DONE : ISSUE) : (tmo ? DONE : WAIT);
            DONE:    state_n = bus.result_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            img_num <= '0;
            best    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                cnt     <= '0;
                img_num <= '0;
                best    <= '0;
            end
            if (state == WAIT && bus.neuron_done) begin
                if (take) begin
                    best    <= bus.neuron_score;
                    img_num <= cnt;
                end
                if (!last) cnt <= cnt + 1'b1;
            end
        end
    end

    // cnt is stable through ISSUE/WAIT and keeps its last value afterwards, so it doubles as neuron_idx.
    assign bus.busy         = state != IDLE;
    assign bus.neuron_req   = state == ISSUE;
    assign bus.neuron_idx   = cnt;
    assign bus.result_valid = state == DONE;
    assign bus.Img_Num      = img_num;
    assign bus.max_score    = best;
    assign bus.err          = err_q;
endmodule
